// File: rtl/vram_host_pkg.sv
// Shared constants and types for the host-side VRAM write front end.
package vram_host_pkg;

  localparam int unsigned VRAM_AW   = 13;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned REG_SEL_W = 2;
  localparam int unsigned CTRL_W    = 2;

  localparam logic [REG_SEL_W-1:0] REG_ADDR_LO = 2'd0;
  localparam logic [REG_SEL_W-1:0] REG_ADDR_HI = 2'd1;
  localparam logic [REG_SEL_W-1:0] REG_DATA    = 2'd2;
  localparam logic [REG_SEL_W-1:0] REG_CTRL    = 2'd3;

  localparam int unsigned CTRL_STRIDE_BIT = 0;
  localparam int unsigned CTRL_INC_BIT    = 1;

  localparam logic [CTRL_W-1:0] CTRL_RESET = 2'b10;

  // One write beat as presented on the VRAM write interface.
  typedef struct packed {
    logic [VRAM_AW-1:0] addr;
    logic [DATA_W-1:0]  data;
  } vramBeat_t;

endpackage

// File: rtl/host_strobe_sync.sv
// Synchronizes the asynchronous host strobe into clk and emits a registered
// one-cycle pulse on its rising edge. Reset parks every stage at "asserted".
module host_strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic strbAsync,
  output logic hit
);

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   strbPrev;

  // Forcing the chain high at reset hides a strobe that is already active.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      syncQ    <= '1;
      strbPrev <= 1'b1;
      hit      <= 1'b0;
    end else begin
      syncQ    <= {syncQ[SYNC_STAGES-2:0], strbAsync};
      strbPrev <= syncQ[SYNC_STAGES-1];
      hit      <= syncQ[SYNC_STAGES-1] & ~strbPrev;
    end
  end

endmodule

// File: rtl/vram_host_writer.sv
// Host register decode, auto-incrementing VRAM address pointer and the
// registered single-cycle VRAM write port.
module vram_host_writer
  import vram_host_pkg::*;
#(
  parameter int unsigned ROW_STRIDE  = 40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 hostCs_n,
  input  logic                 hostWr_n,
  input  logic [REG_SEL_W-1:0] hostRegSel,
  input  logic [DATA_W-1:0]    hostData,
  output logic [VRAM_AW-1:0]   vramWrAddr,
  output logic [DATA_W-1:0]    vramWrData,
  output logic                 vramWr
);

  localparam logic [VRAM_AW-1:0] STEP_ROW = VRAM_AW'(ROW_STRIDE);
  localparam logic [VRAM_AW-1:0] STEP_ONE = VRAM_AW'(1);

  logic               strb;
  logic               hit;
  logic [VRAM_AW-1:0] addr;
  logic [VRAM_AW-1:0] step;
  logic [CTRL_W-1:0]  ctrl;
  vramBeat_t          beat;
  logic               wrPulse;

  assign strb = ~hostCs_n & ~hostWr_n;

  host_strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) uStrobeSync (
    .clk       (clk),
    .nrst      (nrst),
    .strbAsync (strb),
    .hit       (hit)
  );

  assign step = ctrl[CTRL_STRIDE_BIT] ? STEP_ROW : STEP_ONE;

  // Register map decode; address/data are stable by the host contract at hit.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      addr    <= '0;
      ctrl    <= CTRL_RESET;
      beat    <= '0;
      wrPulse <= 1'b0;
    end else begin
      wrPulse <= 1'b0;
      if (hit) begin
        case (hostRegSel)
          REG_ADDR_LO: addr[DATA_W-1:0] <= hostData;
          REG_ADDR_HI: addr[VRAM_AW-1:DATA_W] <= hostData[VRAM_AW-DATA_W-1:0];
          REG_DATA: begin
            beat.addr <= addr;
            beat.data <= hostData;
            wrPulse   <= 1'b1;
            if (ctrl[CTRL_INC_BIT]) begin
              addr <= addr + step;
            end
          end
          REG_CTRL: ctrl <= hostData[CTRL_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign vramWrAddr = beat.addr;
  assign vramWrData = beat.data;
  assign vramWr     = wrPulse;

endmodule
